// File: rtl/neuron_pkg.sv
// Shared Q16.16 constants, FSM state type and saturation helper for the neuron datapath.
package neuron_pkg;

  localparam int FRAC_BITS = 16;
  localparam logic signed [31:0] ONE  = 32'sh0001_0000;
  localparam logic signed [31:0] ZERO = 32'sh0000_0000;

  typedef enum logic {
    SCAN,
    COMMIT
  } syn_state_t;

  // Clamp a wide signed value into the range of a signed width-bit word, sign-extended to 64 bits.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value, input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) begin
      return max_v;
    end else if (value < min_v) begin
      return min_v;
    end
    return value;
  endfunction

endpackage

// File: rtl/spike_edge_latch.sv
// Rising-edge detector per spike line with sticky pending flags; a new edge wins over a scan clear.
module spike_edge_latch #(
  parameter int M = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [M-1:0]         synin,
  input  logic                 clr_en,
  input  logic [$clog2(M)-1:0] clr_idx,
  output logic [M-1:0]         pending
);

  logic [M-1:0] synin_d;
  logic [M-1:0] rise;
  logic [M-1:0] clr_mask;

  assign rise = synin & ~synin_d;

  always_comb begin
    clr_mask = '0;
    if (clr_en) begin
      clr_mask[clr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      synin_d <= '0;
      pending <= '0;
    end else begin
      synin_d <= synin;
      pending <= (pending & ~clr_mask) | rise;
    end
  end

endmodule

// File: rtl/synapse_current.sv
// Synaptic current front end: scans pending spikes, accumulates weights, then decays and
// saturates the output current once every M+1 cycles.
module synapse_current
  import neuron_pkg::*;
#(
  parameter int N           = 32,
  parameter int M           = 8,
  parameter int DECAY_SHIFT = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [M-1:0]         synin,
  input  logic                 wr_en,
  input  logic [$clog2(M)-1:0] wr_addr,
  input  logic [N-1:0]         wr_data,
  output logic signed [N-1:0]  I,
  output logic                 I_valid
);

  localparam int IW = $clog2(M);
  localparam int SW = N + IW + 1;
  localparam int CW = N + IW + 2;

  logic signed [N-1:0]  weight [M];
  syn_state_t           state;
  logic [IW-1:0]        idx;
  logic signed [SW-1:0] sum;
  logic [M-1:0]         pending;
  logic                 clr_en;
  logic signed [CW-1:0] i_ext;
  logic signed [CW-1:0] i_next_wide;
  logic signed [63:0]   i_sat;

  spike_edge_latch #(
    .M(M)
  ) u_edge_latch (
    .clk    (clk),
    .reset  (reset),
    .synin  (synin),
    .clr_en (clr_en),
    .clr_idx(idx),
    .pending(pending)
  );

  assign clr_en = (state == SCAN) && pending[idx];

  // Wide enough that decay plus a full-scale sum cannot wrap before saturation.
  assign i_ext       = CW'(I);
  assign i_next_wide = i_ext - (i_ext >>> DECAY_SHIFT) + CW'(sum);
  assign i_sat       = saturate(64'(i_next_wide), N);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < M; k++) begin
        weight[k] <= '0;
      end
    end else if (wr_en && (int'(wr_addr) < M)) begin
      weight[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= SCAN;
      idx     <= '0;
      sum     <= '0;
      I       <= N'(ZERO);
      I_valid <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          I_valid <= 1'b0;
          if (pending[idx]) begin
            sum <= sum + SW'(weight[idx]);
          end
          if (idx == IW'(M - 1)) begin
            state <= COMMIT;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        COMMIT: begin
          I       <= N'(i_sat);
          I_valid <= 1'b1;
          sum     <= '0;
          idx     <= '0;
          state   <= SCAN;
        end
        default: begin
          state <= SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_synapse_current.sv
// Scoreboard bench for synapse_current: a period-level reference model queues every expected
// current, and a monitor compares each I_valid against it, plus directed Q16.16 scenarios.
module tb_synapse_current;

  localparam int TN = 32;
  localparam int TM = 4;
  localparam int DS = 3;

  logic               clk;
  logic               reset;
  logic [TM-1:0]      synin;
  logic               wr_en;
  logic [1:0]         wr_addr;
  logic signed [31:0] wr_data;
  logic signed [31:0] dut_i;
  logic               dut_valid;

  int     compared;
  int     mismatched;
  longint exp_q[$];
  longint last_i;

  synapse_current #(
    .N          (TN),
    .M          (TM),
    .DECAY_SHIFT(DS)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .synin  (synin),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .I      (dut_i),
    .I_valid(dut_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  task automatic checkOutput(input string name, input longint got, input longint exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h required 0x%08h", name, got[31:0], exp[31:0]);
    end
  endtask

  // Reference model: one scan slot per line, then a commit slot, free-running from reset.
  initial begin
    logic [TM-1:0] m_prev;
    logic [TM-1:0] m_pend;
    logic [TM-1:0] m_rise;
    longint        m_w[TM];
    longint        m_acc;
    longint        m_i;
    int            m_phase;
    m_prev = '0; m_pend = '0; m_acc = 0; m_i = 0; m_phase = 0;
    for (int k = 0; k < TM; k++) m_w[k] = 0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_prev = '0; m_pend = '0; m_acc = 0; m_i = 0; m_phase = 0;
        for (int k = 0; k < TM; k++) m_w[k] = 0;
        exp_q.delete();
      end else begin
        m_rise = synin & ~m_prev;
        if (m_phase < TM) begin
          if (m_pend[m_phase]) begin
            m_acc = m_acc + m_w[m_phase];
            m_pend[m_phase] = 1'b0;
          end
        end else begin
          m_i   = clamp32(m_i - floor_div(m_i, longint'(1) << DS) + m_acc);
          m_acc = 0;
          exp_q.push_back(m_i);
        end
        m_pend = m_pend | m_rise;
        m_prev = synin;
        if (wr_en && (int'(wr_addr) < TM)) m_w[wr_addr] = longint'(wr_data);
        m_phase = (m_phase == TM) ? 0 : m_phase + 1;
      end
    end
  end

  // Monitor: every I_valid consumes one expectation; between commits I must hold.
  initial begin
    longint e;
    last_i = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        last_i = 0;
      end else if (dut_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("sb_unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_I", longint'(dut_i), e);
          last_i = e;
        end
      end else begin
        checkOutput("hold_I", longint'(dut_i), last_i);
        if (exp_q.size() != 0) begin
          checkOutput("sb_missed_valid", longint'(exp_q.size()), 0);
          exp_q.delete();
        end
      end
    end
  end

  task automatic waitValid();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3 * (TM + 1); c++) begin
      @(negedge clk);
      if (dut_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("valid_timeout", 0, 1);
  endtask

  task automatic doReset();
    @(negedge clk);
    synin = '0;
    wr_en = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic writeWeight(input logic [1:0] addr, input logic signed [31:0] data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Raise lines during the commit slot so the next I_valid is stale and the one after counts them.
  task automatic armPulse(input logic [TM-1:0] mask);
    waitValid();
    repeat (TM) @(negedge clk);
    synin = synin | mask;
    waitValid();
  endtask

  task automatic applyStimulus(input int cycles);
    int r;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      wr_en = 1'b0;
      for (int k = 0; k < TM; k++) begin
        if ($urandom_range(5) == 0) synin[k] = ~synin[k];
      end
      if ($urandom_range(7) == 0) begin
        wr_en   = 1'b1;
        wr_addr = 2'($urandom_range(3));
        r = int'($urandom_range(5));
        case (r)
          0, 1, 2: wr_data = 32'($urandom_range(32'h0004_0000)) - 32'h0002_0000;
          3:       wr_data = 32'sh7FFF_0000;
          4:       wr_data = 32'sh8000_0000;
          default: wr_data = 32'($urandom);
        endcase
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    reset   = 1'b1;
    synin   = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_I", longint'(dut_i), 0);
    checkOutput("reset_valid", longint'(dut_valid), 0);
    reset = 1'b0;

    $display("[TB] single pulse and decay");
    writeWeight(2'd0, 32'sh0001_0000);
    armPulse(4'b0001);
    waitValid();
    checkOutput("single_pulse_I", longint'(dut_i), 64'sh0001_0000);
    repeat (2) @(negedge clk);
    synin = '0;
    waitValid();
    checkOutput("decay_I", longint'(dut_i), 64'sh0000_E000);

    $display("[TB] mixed-sign simultaneous pulses");
    doReset();
    writeWeight(2'd0, 32'sh0001_0000);
    writeWeight(2'd1, 32'shFFFF_8000);
    armPulse(4'b0011);
    waitValid();
    checkOutput("mixed_sum_I", longint'(dut_i), 64'sh0000_8000);
    synin = '0;

    $display("[TB] negative decay");
    doReset();
    writeWeight(2'd0, 32'shFFFF_0000);
    armPulse(4'b0001);
    waitValid();
    checkOutput("neg_I", longint'(dut_i), -64'sh0001_0000);
    synin = '0;
    waitValid();
    checkOutput("neg_decay_I", longint'(dut_i), -64'sh0000_E000);

    $display("[TB] saturation");
    doReset();
    for (int k = 0; k < TM; k++) writeWeight(2'(k), 32'sh7FFF_0000);
    armPulse(4'b1111);
    waitValid();
    checkOutput("sat_pos_I", longint'(dut_i), 64'sh7FFF_FFFF);
    synin = '0;
    doReset();
    for (int k = 0; k < TM; k++) writeWeight(2'(k), 32'sh8000_0000);
    armPulse(4'b1111);
    waitValid();
    checkOutput("sat_neg_I", longint'(dut_i), -64'sh8000_0000);
    synin = '0;

    $display("[TB] edge coinciding with scan and commit");
    doReset();
    writeWeight(2'd2, 32'sh0001_0000);
    writeWeight(2'd3, 32'sh0000_4000);
    waitValid();
    synin[2] = 1'b1;
    @(negedge clk);
    synin[2] = 1'b0;
    @(negedge clk);
    synin[2] = 1'b1;
    repeat (2) @(negedge clk);
    synin[3] = 1'b1;
    waitValid();
    checkOutput("scan_hit_I", longint'(dut_i), 64'sh0001_0000);
    waitValid();
    checkOutput("recount_I", longint'(dut_i), 64'sh0002_2000);
    synin = '0;

    $display("[TB] reset mid-scan");
    writeWeight(2'd1, 32'sh0000_3000);
    waitValid();
    synin = 4'b1110;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("midreset_I", longint'(dut_i), 0);
    checkOutput("midreset_valid", longint'(dut_valid), 0);
    synin = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput("reset_hold_valid", longint'(dut_valid), 0);
    end
    reset = 1'b0;
    waitValid();
    checkOutput("post_reset_I", longint'(dut_i), 0);
    armPulse(4'b1111);
    waitValid();
    checkOutput("zero_weight_I", longint'(dut_i), 0);
    synin = '0;

    $display("[TB] randomized traffic");
    applyStimulus(800);
    synin = '0;
    repeat (2 * (TM + 1)) @(negedge clk);
    #1;
    checkOutput("final_queue", longint'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/synapse_current.md
Name: synapse_current

Overview:
Synaptic front end that produces the input current I consumed by the neuron integrator. Detects rising edges on M spike lines (each pulse is held several clocks by the upstream impulse generator). Adds a programmable signed Q16.16 weight for each new spike and applies exponential decay. Presents a saturated N-bit current, updated once per fixed-length update period.

Parameters:
N, 32, data width of weights and I (signed Q16.16 at N=32)
M, 8, number of synaptic inputs (M >= 2)
DECAY_SHIFT, 3, decay per update period is I >>> DECAY_SHIFT

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
synin  input  M  spike lines, one per presynaptic neuron (level pulses)
wr_en  input  1  weight write strobe
wr_addr  input  $clog2(M)  synapse index to write
wr_data  input  N  signed weight, Q16.16
I  output  N  signed synaptic current to the neuron, Q16.16
I_valid  output  1  one-cycle pulse when I has just been updated

Behaviour:
- Interface: one clock, clk. Reset is asynchronous, active-high, named reset.
- Reset values: I=0, I_valid=0, all weights=0, pending=0, synin_d=0, sum=0, state=SCAN, idx=0.
- Edge detect: synin_d <= synin every cycle; rise = synin & ~synin_d.
  - Any rise[k] sets pending[k].
  - A pulse held high for many cycles counts once.
  - Several edges on one line within one period count once.
- FSM, free-running, period M+1 cycles:
  - SCAN, idx 0..M-1, one synapse per cycle. If pending[idx]=1: sum += weight[idx], clear pending[idx]. Then idx++. After idx=M-1, go to COMMIT.
  - COMMIT, 1 cycle: I <= sat(I - (I >>> DECAY_SHIFT) + sum), then I_valid=1, sum <= 0, idx <= 0, go to SCAN.
- Arithmetic:
  - sum is signed, N+$clog2(M)+1 bits; it never overflows.
  - The commit expression is evaluated at N+$clog2(M)+2 bits.
  - The shift is arithmetic (sign-preserving).
  - sat() clamps to [0x8000_0000, 0x7FFF_FFFF] for N=32.
- I stays constant between commits, so the neuron sees a stable current for M+1 cycles.
- Simultaneous rise[k] and scan of k with pending[k]=1: the weight is added, and pending[k] stays 1 (counted again next period).
- Simultaneous rise[k] and scan of k with pending[k]=0: pending[k] is set; the weight is added next period.
- Edges arriving during COMMIT are latched into pending and counted in the next period.
- Weight write: weight[wr_addr] <= wr_data at posedge when wr_en=1.
  - A scan of the same index in the same cycle uses the old weight.
  - A wr_addr >= M is ignored.
- Latency:
  - Edge to I update is at most 2M+2 cycles (edge just missed by the scan).
  - Minimum is 2 cycles (edge registered, then added in the last SCAN slot, then COMMIT).
- Reset mid-period: all state, including accumulated sum and pending edges, is discarded. Weights return to 0; no I_valid is issued.

Decomposition:
- Shared package neuron_pkg:
  - FRAC_BITS=16
  - Q16.16 constants ONE=0x0001_0000 and ZERO
  - signed saturate-to-N function, reused by the integrator
- Natural sub-module spike_edge_latch (parameter M): holds synin_d and pending, has inputs clr_en/clr_idx, and applies the set-wins-over-clear rule.
- The weight register file and FSM/accumulator stay in synapse_current.

Test Plan:
- Config M=4, DECAY_SHIFT=3, weight[0]=0x0001_0000. Single 8-cycle pulse on synin[0] -> I=0x0001_0000 at the first I_valid after the edge. Next commit, no spikes -> I=0x0000_E000.
- Weights {0x0001_0000, 0xFFFF_8000, 0, 0}. Simultaneous pulses on synin[0] and synin[1] -> I=0x0000_8000 after one commit.
- I=0xFFFF_0000 (-1.0) with no spikes -> next commit I=0xFFFF_2000 (-0.875). Sign is preserved by the arithmetic shift.
- All weights 0x7FFF_0000, all four lines spike -> I=0x7FFF_FFFF. Same with weights 0x8000_0000 -> I=0x8000_0000.
- Rising edge on synin[2] in the cycle idx=2 is scanned, with pending[2] already 1:
  - weight added this period and again the next period (two contributions);
  - a rise on synin[3] during COMMIT is added in the next period only.
- Assert reset during SCAN with pending edges and nonzero sum -> I=0, I_valid=0, weights=0 immediately. After release, the first commit gives I=0 with no spikes.
